// File: rtl/irq_pending_arb.sv
// Interrupt request capture and arbitration: rising-edge detect into a pending register,
// fixed priority (bit 7 highest) over the unmasked set, valid/ack handshake. Option: IRQ_OVF_EN.
module irq_pending_arb #(
    parameter logic [7:0] MASK_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       mask_wr,
    input  logic [7:0] mask_in,
    input  logic       irq_ack,
    output logic       irq_valid,
    output logic [2:0] irq_idx,
    output logic [7:0] pending,
    output logic [7:0] mask
`ifdef IRQ_OVF_EN
    ,
    output logic [7:0] ovf
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] idx_next;
    logic [7:0] req_d;
    logic [7:0] edge_det;
    logic [7:0] clr;
    logic [7:0] eligible;
    logic [2:0] winner;

    assign edge_det  = req & ~req_d;
    assign clr       = (irq_valid && irq_ack) ? (8'd1 << irq_idx) : 8'd0;
    assign eligible  = pending & mask;
    // The state flop doubles as the valid flag, keeping irq_valid registered.
    assign irq_valid = (state == PRESENT);

    // Ascending scan: the last set bit seen, i.e. the highest, wins.
    always_comb begin
        winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) winner = i[2:0];
        end
    end

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = irq_idx;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    idx_next   = winner;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                // No pre-emption: only an ack or masking of the presented bit releases it.
                if (irq_ack || !mask[irq_idx]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            irq_idx <= 3'd0;
            req_d   <= 8'h00;
            pending <= 8'h00;
            mask    <= MASK_RST;
        end else begin
            state   <= state_next;
            irq_idx <= idx_next;
            req_d   <= req;
            // Set after clear: a new edge on the bit being acknowledged keeps it pending.
            pending <= (pending & ~clr) | edge_det;
            if (mask_wr) mask <= mask_in;
        end
    end

`ifdef IRQ_OVF_EN
    logic [7:0] ovf_set;
    logic [7:0] ovf_clr;

    assign ovf_set = edge_det & pending & ~clr;
    // A fresh edge on the acknowledged bit suppresses that bit's overflow clear.
    assign ovf_clr = clr & ~edge_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 8'h00;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end
`endif

endmodule

// File: tb/tb_irq_pending_arb.sv
// Directed, table-driven bench for irq_pending_arb plus hand sequences for
// asynchronous reset and (with IRQ_OVF_EN) the overflow flags.
module tb_irq_pending_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic [7:0] pending;
    logic [7:0] mask;
`ifdef IRQ_OVF_EN
    logic [7:0] ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_pending_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .pending   (pending),
        .mask      (mask)
`ifdef IRQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       mask_wr;
        logic [7:0] mask_in;
        logic       ack;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
        logic [7:0] msk;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [2:0] i,
                             input logic [7:0] p, input logic [7:0] m);
        check({tag, " valid"},   {7'd0, irq_valid}, {7'd0, v});
        check({tag, " idx"},     {5'd0, irq_idx},   {5'd0, i});
        check({tag, " pending"}, pending,           p);
        check({tag, " mask"},    mask,              m);
    endtask

    task automatic drive(input logic r, input logic [7:0] rq, input logic mw,
                         input logic [7:0] mi, input logic a);
        rst     = r;
        req     = rq;
        mask_wr = mw;
        mask_in = mi;
        irq_ack = a;
    endtask

    initial begin
        // Each row: inputs held across one rising edge, outputs expected just after it.
        //               rst   req    mw    mi     ack   valid idx   pend   mask
        vecs.push_back('{1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h04, 8'hFF}); // 1 single request
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04, 8'hFF});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04, 8'hFF});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 8'hFF}); // 5
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 8'hFF}); // ack while idle
        vecs.push_back('{1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h11, 8'hFF}); // priority
        vecs.push_back('{1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 8'h11, 8'hFF});
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 8'h91, 8'hFF}); // bit 7 arrives, held at 4
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 8'h81, 8'hFF}); // 10
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'h81, 8'hFF});
        vecs.push_back('{1'b0, 8'h91, 1'b1, 8'h7F, 1'b0, 1'b1, 3'd7, 8'h81, 8'h7F}); // mask bit 7
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 8'h81, 8'h7F});
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h81, 8'h7F});
        vecs.push_back('{1'b0, 8'h91, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h81, 8'hFF}); // 15 unmask
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h80, 8'hFF});
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80, 8'hFF});
        vecs.push_back('{1'b0, 8'h91, 1'b0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08, 8'hFF}); // 20 collision
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 8'hFF});
        vecs.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h08, 8'hFF});
        vecs.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 8'hFF});
        vecs.push_back('{1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 8'hFF}); // 25
        vecs.push_back('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00}); // mask all
        vecs.push_back('{1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h02, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h02, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h02, 8'hFF});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 8'h02, 8'hFF}); // 30
        vecs.push_back('{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 8'hFF});
        vecs.push_back('{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF}); // reset, req high
        vecs.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'hFF, 8'hFF}); // counts as edge
        vecs.push_back('{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'hFF, 8'hFF});

        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all("reset", 1'b0, 3'd0, 8'h00, 8'hFF);
`ifdef IRQ_OVF_EN
        check("reset ovf", ovf, 8'h00);
`endif

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].rst, vecs[n].req, vecs[n].mask_wr, vecs[n].mask_in, vecs[n].ack);
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", n + 1), vecs[n].valid, vecs[n].idx,
                      vecs[n].pend, vecs[n].msk);
        end

        // Asynchronous reset while presenting index 7 with pending = 8'h81.
        @(negedge clk);
        drive(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h81, 1'b1, 8'hF1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_all("pre_rst", 1'b1, 3'd7, 8'h81, 8'hF1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 3'd0, 8'h00, 8'hFF);
        @(negedge clk);
        rst = 1'b0;

`ifdef IRQ_OVF_EN
        // Second edge on bit 5 while it is pending, then acknowledge it.
        @(negedge clk);
        drive(1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        req = 8'h20;
        @(posedge clk);
        #1;
        check("ovf set", ovf, 8'h20);
        check("ovf idx", {5'd0, irq_idx}, 8'd5);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        check("ovf clr", ovf, 8'h00);
        check("ovf pend", pending, 8'h00);
        @(negedge clk);
        irq_ack = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
